// File: rtl/exe_stage_muldiv.sv
// Execute stage with EXE/MEM pipeline register and an optional 32-cycle iterative mul/div unit.
// Define EXE_MULDIV_EN to build the multiply/divide FSM; when undefined, stall is tied low.
module exe_stage_muldiv #(
  parameter int XLEN = 32
`ifdef EXE_MULDIV_EN
  ,
  parameter int MD_CYCLES = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [3:0]      EXE_CMD,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] ST_val,
  input  logic [XLEN-1:0] PC,
  input  logic [4:0]      dest,
  input  logic            WB_EN,
  input  logic            MEM_R_EN,
  input  logic            MEM_W_EN,
  output logic            stall,
  output logic            WB_EN_out,
  output logic            MEM_R_EN_out,
  output logic            MEM_W_EN_out,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] ALU_res_out,
  output logic [XLEN-1:0] ST_value_out,
  output logic [4:0]      dest_out
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  logic [XLEN-1:0] alu_res;
  logic            out_bubble;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  logic            wb_en_q, wb_en_d;
  logic            mem_r_en_q, mem_r_en_d;
  logic            mem_w_en_q, mem_w_en_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic [XLEN-1:0] st_value_q, st_value_d;
  logic [4:0]      dest_q, dest_d;

  always_comb begin
    alu_res = '0;
    case (EXE_CMD)
      OP_ADD:  alu_res = val1 + val2;
      OP_SUB:  alu_res = val1 - val2;
      OP_AND:  alu_res = val1 & val2;
      OP_OR:   alu_res = val1 | val2;
      OP_NOR:  alu_res = ~(val1 | val2);
      OP_XOR:  alu_res = val1 ^ val2;
      OP_SLL:  alu_res = val1 << val2[4:0];
      OP_SRL:  alu_res = val1 >> val2[4:0];
      OP_SRA:  alu_res = $signed(val1) >>> val2[4:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  // md_a: multiplicand (mul) or dividend shifting into quotient (div); md_b: multiplier or divisor
  logic [XLEN-1:0] md_a_q, md_a_d;
  logic [XLEN-1:0] md_b_q, md_b_d;
  logic [XLEN-1:0] md_acc_q, md_acc_d;
  logic            is_mul_q, is_mul_d;
  logic            is_quo_q, is_quo_d;
  logic            md_cmd;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  assign md_cmd    = (EXE_CMD == OP_MUL) || (EXE_CMD == OP_DIVU) || (EXE_CMD == OP_REMU);
  assign div_shift = {md_acc_q, md_a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, md_b_q};
  assign div_ge    = div_shift >= {1'b0, md_b_q};
  assign md_result = is_quo_q ? md_a_q : md_acc_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    md_acc_d   = md_acc_q;
    is_mul_d   = is_mul_q;
    is_quo_d   = is_quo_q;
    stall      = 1'b0;
    out_bubble = 1'b0;
    md_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_cmd) begin
          stall      = 1'b1;
          out_bubble = 1'b1;
          state_d    = BUSY;
          count_d    = '0;
          md_a_d     = val1;
          md_b_d     = val2;
          md_acc_d   = '0;
          is_mul_d   = (EXE_CMD == OP_MUL);
          is_quo_d   = (EXE_CMD == OP_DIVU);
        end
      end
      BUSY: begin
        stall      = 1'b1;
        out_bubble = 1'b1;
        count_d    = count_q + 1'b1;
        if (is_mul_q) begin
          md_acc_d = md_b_q[0] ? (md_acc_q + md_a_q) : md_acc_q;
          md_a_d   = md_a_q << 1;
          md_b_d   = md_b_q >> 1;
        end else begin
          // Restoring step: a zero divisor always "fits", giving all-ones quotient and rem = dividend
          md_acc_d = XLEN'(div_ge ? div_diff : div_shift);
          md_a_d   = {md_a_q[XLEN-2:0], div_ge};
        end
        if (count_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      out_bubble = 1'b1;
      md_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      md_a_q   <= '0;
      md_b_q   <= '0;
      md_acc_q <= '0;
      is_mul_q <= 1'b0;
      is_quo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      md_a_q   <= md_a_d;
      md_b_q   <= md_b_d;
      md_acc_q <= md_acc_d;
      is_mul_q <= is_mul_d;
      is_quo_q <= is_quo_d;
    end
  end
`else
  assign stall      = 1'b0;
  assign out_bubble = flush;
  assign md_done    = 1'b0;
  assign md_result  = '0;
`endif

  always_comb begin
    wb_en_d    = WB_EN;
    mem_r_en_d = MEM_R_EN;
    mem_w_en_d = MEM_W_EN;
    pc_d       = PC;
    alu_res_d  = md_done ? md_result : alu_res;
    st_value_d = ST_val;
    dest_d     = dest;
    if (out_bubble) begin
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      mem_w_en_d = 1'b0;
      pc_d       = '0;
      alu_res_d  = '0;
      st_value_d = '0;
      dest_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      pc_q       <= '0;
      alu_res_q  <= '0;
      st_value_q <= '0;
      dest_q     <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      pc_q       <= pc_d;
      alu_res_q  <= alu_res_d;
      st_value_q <= st_value_d;
      dest_q     <= dest_d;
    end
  end

  assign WB_EN_out    = wb_en_q;
  assign MEM_R_EN_out = mem_r_en_q;
  assign MEM_W_EN_out = mem_w_en_q;
  assign PC_out       = pc_q;
  assign ALU_res_out  = alu_res_q;
  assign ST_value_out = st_value_q;
  assign dest_out     = dest_q;

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed scoreboard bench for exe_stage_muldiv; adapts its expectations to EXE_MULDIV_EN.
module tb_exe_stage_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  exeCmd;
  logic [31:0] val1, val2, stVal, pc;
  logic [4:0]  dest;
  logic        wbEn, memREn, memWEn;
  logic        stall;
  logic        wbEnOut, memREnOut, memWEnOut;
  logic [31:0] pcOut, aluResOut, stValueOut;
  logic [4:0]  destOut;

  typedef struct {
    logic        wb, mr, mw;
    logic [31:0] pc, res, st;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  exe_stage_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush), .EXE_CMD(exeCmd),
    .val1(val1), .val2(val2), .ST_val(stVal), .PC(pc), .dest(dest),
    .WB_EN(wbEn), .MEM_R_EN(memREn), .MEM_W_EN(memWEn), .stall(stall),
    .WB_EN_out(wbEnOut), .MEM_R_EN_out(memREnOut), .MEM_W_EN_out(memWEnOut),
    .PC_out(pcOut), .ALU_res_out(aluResOut), .ST_value_out(stValueOut),
    .dest_out(destOut)
  );

  always #5 clk = ~clk;

  // Behavioural reference using plain operators rather than iteration
  function automatic logic [31:0] modelAlu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (c)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1010: r = $signed(a) >>> b[4:0];
`ifdef EXE_MULDIV_EN
      4'b1100: r = a * b;
      4'b1101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1110: r = (b == 0) ? a : a % b;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] st, input logic [31:0] p, input logic [4:0] d,
                               input logic wb, input logic mr, input logic mw,
                               input bit expectResult);
    exp_t e;
    exeCmd = c; val1 = a; val2 = b; stVal = st; pc = p; dest = d;
    wbEn = wb; memREn = mr; memWEn = mw;
    if (expectResult) begin
      e.wb = wb; e.mr = mr; e.mw = mw; e.pc = p; e.st = st; e.dest = d;
      e.res = modelAlu(c, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_res"},  aluResOut, e.res);
    cmp({tag, "_ctl"},  {29'd0, wbEnOut, memREnOut, memWEnOut}, {29'd0, e.wb, e.mr, e.mw});
    cmp({tag, "_dest"}, {27'd0, destOut}, {27'd0, e.dest});
    cmp({tag, "_pc"},   pcOut, e.pc);
    cmp({tag, "_st"},   stValueOut, e.st);
  endtask

  task automatic checkBubble(input string tag);
    cmp({tag, "_ctl"}, {24'd0, wbEnOut, memREnOut, memWEnOut, destOut}, 32'd0);
    cmp({tag, "_res"}, aluResOut, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkBubble(tag);
    cmp({tag, "_pc"}, pcOut, 32'd0);
    cmp({tag, "_st"}, stValueOut, 32'd0);
    cmp({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

`ifdef EXE_MULDIV_EN
  // Counts stall cycles with a bound, checks bubbles on each stalled edge, then the result
  task automatic runMulDiv(input string tag);
    int stallCnt;
    stallCnt = 0;
    while (stall === 1'b1 && stallCnt < 100) begin
      stallCnt++;
      tick;
      checkBubble({tag, "_bubble"});
    end
    cmp({tag, "_stall_cycles"}, stallCnt, 32'd33);
    tick;
    checkOutput(tag);
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0;
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    checkAllZero("reset");
    rst = 1'b0;

    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h1111_2222, 32'h100, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("add_wrap");
    applyStimulus(4'b1010, 32'h8000_0000, 32'd4, 32'd0, 32'h104, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("sra");
    applyStimulus(4'b0010, 32'd0, 32'd1, 32'hABCD, 32'h108, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    tick; checkOutput("sub_wrap");
    applyStimulus(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'h10C, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick; checkOutput("nor");
    applyStimulus(4'b0111, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'd0, 32'h110, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("xor");
    applyStimulus(4'b1000, 32'h0000_0003, 32'h0000_003F, 32'd0, 32'h114, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("sll31");
    applyStimulus(4'b1001, 32'h8000_0000, 32'd31, 32'd0, 32'h118, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("srl31");
    applyStimulus(4'b0011, 32'h1234, 32'h5678, 32'd0, 32'h11C, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("undef_op");

`ifdef EXE_MULDIV_EN
    applyStimulus(4'b1100, 32'h0001_0003, 32'h0002_0005, 32'h55, 32'h200, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("mul");
    applyStimulus(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h204, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("mul_max");
    applyStimulus(4'b1101, 32'd100, 32'd7, 32'd0, 32'h208, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("divu");
    applyStimulus(4'b1110, 32'd100, 32'd7, 32'd0, 32'h20C, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("remu");
    applyStimulus(4'b1101, 32'd5, 32'd0, 32'd0, 32'h210, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("divu_zero");
    applyStimulus(4'b1110, 32'd5, 32'd0, 32'd0, 32'h214, 5'd18, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("remu_zero");
    applyStimulus(4'b1101, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h218, 5'd19, 1'b1, 1'b0, 1'b0, 1'b1);
    runMulDiv("divu_big");

    // Flush a multiply after ten iterations; the next ADD must not see a stale product
    applyStimulus(4'b1100, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'h300, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("flush_stall_start", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 11; i++) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    applyStimulus(4'b0000, 32'd1, 32'd1, 32'd0, 32'h304, 5'd21, 1'b1, 1'b0, 1'b0, 1'b1);
    checkBubble("flush_bubble");
    cmp("flush_stall_drop", {31'd0, stall}, 32'd0);
    tick; checkOutput("after_flush_add");

    // Reset in the middle of a divide
    applyStimulus(4'b1101, 32'd100, 32'd7, 32'd0, 32'h400, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    applyStimulus(4'b0000, 32'd1, 32'd1, 32'h77, 32'h404, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0);
    tick; tick;
    checkAllZero("rst_mid_div");
    rst = 1'b0;
    applyStimulus(4'b0000, 32'd2, 32'd3, 32'd0, 32'h408, 5'd24, 1'b1, 1'b0, 1'b0, 1'b1);
    tick; checkOutput("after_rst_add");
`else
    applyStimulus(4'b1100, 32'd3, 32'd4, 32'h9, 32'h200, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("mul_off_stall", {31'd0, stall}, 32'd0);
    tick; checkOutput("mul_off");
    applyStimulus(4'b1101, 32'd100, 32'd7, 32'd0, 32'h204, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("divu_off_stall", {31'd0, stall}, 32'd0);
    tick; checkOutput("divu_off");
    applyStimulus(4'b1110, 32'd100, 32'd7, 32'd0, 32'h208, 5'd15, 1'b0, 1'b1, 1'b0, 1'b1);
    tick; checkOutput("remu_off");
    applyStimulus(4'b0000, 32'd1, 32'd1, 32'd0, 32'h20C, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checkBubble("flush_off");
`endif

    // Hold reset for two cycles mid-stream with live inputs
    applyStimulus(4'b0101, 32'h1234_0000, 32'h0000_5678, 32'h99, 32'h500, 5'd25, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    rst = 1'b1;
    tick; tick;
    checkAllZero("rst_mid_stream");
    rst = 1'b0;
    applyStimulus(4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h42, 32'h504, 5'd26, 1'b1, 1'b0, 1'b1, 1'b1);
    tick; checkOutput("and_after_rst");

    cmp("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
